// File: rtl/stb_req_arbiter.sv
// Round-robin arbiter sharing one strobe generator among N_CH channel controllers.
// Optional grant watchdog is compiled in with `define STB_ARB_TIMEOUT_EN.
module stb_req_arbiter #(
    parameter int N_CH      = 4,
    parameter int TO_CYCLES = 4096,
    parameter int TO_W      = 16
) (
    input  logic                      clk_i,
    input  logic                      arstn_i,
    input  logic [N_CH-1:0]           req_i,
    output logic [N_CH-1:0]           valid_o,
    output logic [N_CH-1:0]           to_err_o,
    output logic [N_CH-1:0]           gnt_o,
    output logic [$clog2(N_CH)-1:0]   gnt_id_o,
    output logic                      busy_o,
    input  logic                      stb_rdy_i,
    output logic                      stb_req_o,
    input  logic                      stb_valid_i
);

    localparam int ID_W = $clog2(N_CH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GNT  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    if (N_CH < 2 || N_CH > 16 || TO_W < 1 || TO_W > 31 ||
        TO_CYCLES < 1 || TO_CYCLES >= (1 << TO_W)) begin : g_bad_cfg
        $error("stb_req_arbiter: parameter out of range");
    end

    logic [1:0]      state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_nxt;
    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic [N_CH-1:0] win_oh;
    logic            owner_req;
    logic            wd_exp;

    // Scan from ptr upward with wrap; the lowest offset from ptr wins.
    always_comb begin
        int idx;
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (req_i[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    assign win_oh    = N_CH'(1) << win_id;
    assign ptr_nxt   = (gnt_id_o == ID_W'(N_CH - 1)) ? '0 : gnt_id_o + 1'b1;
    assign owner_req = req_i[gnt_id_o];

`ifdef STB_ARB_TIMEOUT_EN
    logic [TO_W-1:0] wd_cnt;

    assign wd_exp = (wd_cnt == TO_W'(TO_CYCLES - 1));

    // Counter restarts from zero on every grant and saturates instead of wrapping.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wd_cnt <= '0;
        end else if (state != S_GNT) begin
            wd_cnt <= '0;
        end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Valid and abort take precedence over expiry, mirroring the FSM below.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            to_err_o <= '0;
        end else if (state == S_GNT && !stb_valid_i && owner_req && wd_exp) begin
            to_err_o <= gnt_o;
        end else begin
            to_err_o <= '0;
        end
    end
`else
    assign wd_exp   = 1'b0;
    assign to_err_o = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state     <= S_IDLE;
            ptr       <= '0;
            gnt_o     <= '0;
            gnt_id_o  <= '0;
            busy_o    <= 1'b0;
            stb_req_o <= 1'b0;
            valid_o   <= '0;
        end else begin
            valid_o <= '0;
            case (state)
                S_IDLE: begin
                    if (stb_rdy_i && win_found) begin
                        state     <= S_GNT;
                        gnt_o     <= win_oh;
                        gnt_id_o  <= win_id;
                        busy_o    <= 1'b1;
                        stb_req_o <= 1'b1;
                    end
                end
                S_GNT: begin
                    if (stb_valid_i) begin
                        state     <= S_REL;
                        stb_req_o <= 1'b0;
                        valid_o   <= gnt_o;
                        ptr       <= ptr_nxt;
                    end else if (!owner_req) begin
                        state     <= S_IDLE;
                        stb_req_o <= 1'b0;
                        gnt_o     <= '0;
                        busy_o    <= 1'b0;
                        ptr       <= ptr_nxt;
                    end else if (wd_exp) begin
                        state     <= S_REL;
                        stb_req_o <= 1'b0;
                        ptr       <= ptr_nxt;
                    end
                end
                S_REL: begin
                    state  <= S_IDLE;
                    gnt_o  <= '0;
                    busy_o <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    gnt_o     <= '0;
                    busy_o    <= 1'b0;
                    stb_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stb_req_arbiter.sv
// Directed self-checking bench for stb_req_arbiter; expected grant owners are queued
// as stimulus is applied and popped when the grant appears.
module tb_stb_req_arbiter;

    localparam int N_CH      = 4;
    localparam int TO_CYCLES = 16;
    localparam int TO_W      = 16;

    logic            clk_i       = 1'b0;
    logic            arstn_i     = 1'b0;
    logic [N_CH-1:0] req_i       = '0;
    logic            stb_rdy_i   = 1'b0;
    logic            stb_valid_i = 1'b0;
    logic [N_CH-1:0] valid_o;
    logic [N_CH-1:0] to_err_o;
    logic [N_CH-1:0] gnt_o;
    logic [1:0]      gnt_id_o;
    logic            busy_o;
    logic            stb_req_o;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int valid_cnt[N_CH];

    stb_req_arbiter #(
        .N_CH      (N_CH),
        .TO_CYCLES (TO_CYCLES),
        .TO_W      (TO_W)
    ) dut (
        .clk_i       (clk_i),
        .arstn_i     (arstn_i),
        .req_i       (req_i),
        .valid_o     (valid_o),
        .to_err_o    (to_err_o),
        .gnt_o       (gnt_o),
        .gnt_id_o    (gnt_id_o),
        .busy_o      (busy_o),
        .stb_rdy_i   (stb_rdy_i),
        .stb_req_o   (stb_req_o),
        .stb_valid_i (stb_valid_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_reset();
        arstn_i     = 1'b0;
        req_i       = '0;
        stb_valid_i = 1'b0;
        step(2);
        arstn_i = 1'b1;
        step(1);
    endtask

    // Bounded wait for stb_req_o, then compare the owner against the queue head.
    task automatic wait_grant(input string tag, output int exp_id);
        int cyc;
        cyc = 0;
        while (stb_req_o !== 1'b1 && cyc < 16) begin
            step(1);
            cyc++;
        end
        exp_id = exp_q.pop_front();
        check({tag, "_stb_req"}, 32'(stb_req_o), 32'd1);
        check({tag, "_gnt_id"},  32'(gnt_id_o),  32'(exp_id));
        check({tag, "_gnt_oh"},  32'(gnt_o),     32'(1) << exp_id);
        check({tag, "_busy"},    32'(busy_o),    32'd1);
    endtask

    // One-cycle stb_valid_i pulse; valid_o must hit the owner for exactly one cycle.
    task automatic pulse_valid(input string tag, input int owner);
        stb_valid_i = 1'b1;
        step(1);
        for (int k = 0; k < N_CH; k++) if (valid_o[k] === 1'b1) valid_cnt[k]++;
        check({tag, "_valid"},      32'(valid_o),   32'(1) << owner);
        check({tag, "_req_drop"},   32'(stb_req_o), 32'd0);
        check({tag, "_no_err"},     32'(to_err_o),  32'd0);
        stb_valid_i = 1'b0;
        step(1);
        check({tag, "_valid_1cyc"}, 32'(valid_o),   32'd0);
        check({tag, "_idle"},       32'(busy_o),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int id;
        int bad;

        // Reset values
        step(2);
        check("reset_outputs", 32'({stb_req_o, valid_o, to_err_o, gnt_o, gnt_id_o, busy_o}), 32'd0);
        arstn_i = 1'b1;
        step(1);

        // Single channel: grant one cycle after request, then valid routed back
        stb_rdy_i = 1'b1;
        req_i     = 4'b0010;
        step(1);
        check("single_latency", 32'(stb_req_o), 32'd1);
        exp_q.push_back(1);
        wait_grant("single", id);
        pulse_valid("single", id);
        check("single_gnt_clr",  32'(gnt_o),    32'd0);
        check("single_id_hold",  32'(gnt_id_o), 32'd1);
        req_i = '0;

        // stb_valid_i while idle is ignored
        stb_valid_i = 1'b1;
        step(1);
        check("idle_valid_ign", 32'(valid_o), 32'd0);
        check("idle_busy",      32'(busy_o),  32'd0);
        stb_valid_i = 1'b0;
        step(1);

        // Fairness from ptr=0 with all channels requesting
        do_reset();
        for (int k = 0; k < N_CH; k++) valid_cnt[k] = 0;
        req_i = 4'b1111;
        for (int r = 0; r < 2; r++) for (int k = 0; k < N_CH; k++) exp_q.push_back(k);
        for (int g = 0; g < 8; g++) begin
            wait_grant("fair", id);
            pulse_valid("fair", id);
        end
        req_i = '0;
        for (int k = 0; k < N_CH; k++) check("fair_count", 32'(valid_cnt[k]), 32'd2);

        // Not ready holds off arbitration; stb_rdy_i dropping mid-grant does not abort
        do_reset();
        stb_rdy_i = 1'b0;
        req_i     = 4'b0001;
        bad       = 0;
        repeat (20) begin
            step(1);
            if (stb_req_o !== 1'b0) bad++;
        end
        check("nrdy_hold", 32'(bad), 32'd0);
        stb_rdy_i = 1'b1;
        step(1);
        check("nrdy_latency", 32'(stb_req_o), 32'd1);
        exp_q.push_back(0);
        wait_grant("nrdy", id);
        stb_rdy_i = 1'b0;
        step(1);
        check("rdy_fall_hold", 32'(stb_req_o), 32'd1);
        pulse_valid("rdy_fall", id);
        stb_rdy_i = 1'b1;
        req_i     = '0;

        // Abort: owner drops request, ptr still advances past it
        req_i = 4'b0100;
        exp_q.push_back(2);
        wait_grant("abort", id);
        req_i = 4'b1010;
        step(1);
        check("abort_req",   32'(stb_req_o), 32'd0);
        check("abort_gnt",   32'(gnt_o),     32'd0);
        check("abort_valid", 32'(valid_o),   32'd0);
        exp_q.push_back(3);
        wait_grant("abort_next", id);

        // Valid and request drop in the same cycle: valid wins
        stb_valid_i = 1'b1;
        req_i       = 4'b0010;
        step(1);
        check("sim_valid", 32'(valid_o),   32'b1000);
        check("sim_req",   32'(stb_req_o), 32'd0);
        stb_valid_i = 1'b0;
        step(1);
        check("sim_valid_1cyc", 32'(valid_o), 32'd0);
        exp_q.push_back(1);
        wait_grant("after_sim", id);
        pulse_valid("after_sim", id);
        req_i = '0;

        // Watchdog
        do_reset();
        req_i = 4'b0001;
        exp_q.push_back(0);
        wait_grant("wd", id);
        bad = 0;
`ifdef STB_ARB_TIMEOUT_EN
        repeat (TO_CYCLES - 1) begin
            step(1);
            if (to_err_o !== '0 || stb_req_o !== 1'b1) bad++;
        end
        check("wd_quiet", 32'(bad), 32'd0);
        step(1);
        check("wd_err",   32'(to_err_o),  32'b0001);
        check("wd_valid", 32'(valid_o),   32'd0);
        check("wd_req",   32'(stb_req_o), 32'd0);
        req_i = '0;
        step(1);
        check("wd_err_1cyc", 32'(to_err_o), 32'd0);
        check("wd_idle",     32'(busy_o),   32'd0);
`else
        repeat (40) begin
            step(1);
            if (to_err_o !== '0 || stb_req_o !== 1'b1 || gnt_o !== 4'b0001) bad++;
        end
        check("wd_off_hold", 32'(bad), 32'd0);
        req_i = '0;
        step(1);
        check("wd_off_release", 32'(stb_req_o), 32'd0);
        check("wd_off_valid",   32'(valid_o),   32'd0);
`endif

        // Reset mid-grant clears outputs asynchronously and restarts the scan at 0
        req_i = 4'b0100;
        exp_q.push_back(2);
        wait_grant("rst", id);
        #2 arstn_i = 1'b0;
        #1 check("rst_async", 32'({stb_req_o, valid_o, to_err_o, gnt_o, gnt_id_o, busy_o}), 32'd0);
        step(1);
        req_i = '0;
        step(1);
        arstn_i = 1'b1;
        req_i   = 4'b1000;
        exp_q.push_back(3);
        wait_grant("rst_ptr", id);
        pulse_valid("rst_ptr", id);
        req_i = '0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
